// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe game core.
// Contents: cell/reject/FSM enums, board geometry constants, cell_at() board lookup.
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned POS_W     = 4;
  localparam int unsigned BOARD_W   = 2 * NUM_CELLS;
  localparam int unsigned COUNT_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // REJ_NONE is only the reset value of the code register.
  typedef enum logic [1:0] {
    REJ_NONE     = 2'b00,
    REJ_RANGE    = 2'b01,
    REJ_OCCUPIED = 2'b10,
    REJ_FULL     = 2'b11
  } reject_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    ISSUE,
    RELEASE_WAIT,
    RELEASE_DB
  } move_state_t;

  // Cell k lives at bits [17-2k : 16-2k]; out-of-range k reads as EMPTY.
  function automatic cell_t cell_at(input logic [BOARD_W-1:0] board,
                                    input logic [POS_W-1:0]   k);
    cell_t c;
    c = EMPTY;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (k == POS_W'(i)) c = cell_t'(board[BOARD_W-2-2*i +: 2]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tictactoe_sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module tictactoe_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tictactoe_move_input.sv
// Move-input stage: debounces the confirm button, latches the switch position,
// pre-validates against the board and issues single-cycle move/reject strobes.
// Ports: clk, reset (sync, active-high), btn_confirm, sw_position (raw async),
//   board_in, game_over (from core); move_strobe/move_position/move_player,
//   reject_strobe/reject_code, next_player, move_count (all registered).
module tictactoe_move_input
  import tictactoe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_confirm,
  input  logic [3:0]   sw_position,
  input  logic [17:0]  board_in,
  input  logic         game_over,
  output logic         move_strobe,
  output logic [3:0]   move_position,
  output logic         move_player,
  output logic         reject_strobe,
  output logic [1:0]   reject_code,
  output logic         next_player,
  output logic [3:0]   move_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_MOVES = COUNT_W'(NUM_CELLS);
  localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(NUM_CELLS - 1);

  logic             btn_s;
  logic [POS_W-1:0] pos_s;

  move_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               move_strobe_d, reject_strobe_d;
  reject_t            reject_code_d;
  logic [POS_W-1:0]   move_position_d;
  logic               move_player_d, next_player_d;
  logic [COUNT_W-1:0] move_count_d;

  tictactoe_sync2 #(.WIDTH(1)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_confirm),
    .q     (btn_s)
  );

  tictactoe_sync2 #(.WIDTH(POS_W)) u_sync_pos (
    .clk   (clk),
    .reset (reset),
    .d     (sw_position),
    .q     (pos_s)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      move_strobe   <= 1'b0;
      reject_strobe <= 1'b0;
      reject_code   <= REJ_NONE;
      move_position <= '0;
      move_player   <= 1'b0;
      next_player   <= 1'b0;
      move_count    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      move_strobe   <= move_strobe_d;
      reject_strobe <= reject_strobe_d;
      reject_code   <= reject_code_d;
      move_position <= move_position_d;
      move_player   <= move_player_d;
      next_player   <= next_player_d;
      move_count    <= move_count_d;
    end
  end

  // Next-state, debounce counter and next output values
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    move_strobe_d   = 1'b0;
    reject_strobe_d = 1'b0;
    reject_code_d   = reject_t'(reject_code);
    move_position_d = move_position;
    move_player_d   = move_player;
    next_player_d   = next_player;
    move_count_d    = move_count;

    unique case (state_q)
      IDLE: begin
        if (btn_s && !game_over) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end

      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = ISSUE;
          move_position_d = pos_s;
          move_player_d   = next_player;
          // Strobes are registered, so game_over is judged at the edge entering ISSUE.
          if (!game_over) begin
            if (move_count == MAX_MOVES) begin
              reject_strobe_d = 1'b1;
              reject_code_d   = REJ_FULL;
            end else if (pos_s > LAST_POS) begin
              reject_strobe_d = 1'b1;
              reject_code_d   = REJ_RANGE;
            end else if (cell_at(board_in, pos_s) != EMPTY) begin
              reject_strobe_d = 1'b1;
              reject_code_d   = REJ_OCCUPIED;
            end else begin
              move_strobe_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ISSUE: begin
        state_d = RELEASE_WAIT;
        // Turn/count bookkeeping commits on the edge leaving ISSUE.
        if (move_strobe) begin
          next_player_d = ~next_player;
          move_count_d  = (move_count == MAX_MOVES) ? move_count
                                                    : move_count + COUNT_W'(1);
        end
      end

      RELEASE_WAIT: begin
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end

      RELEASE_DB: begin
        if (btn_s) begin
          state_d = RELEASE_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tictactoe_move_input.sv
// Scoreboard bench for tictactoe_move_input with DEBOUNCE_CYCLES=4.
// Stimulus pushes expected strobe events; a negedge monitor pops and compares.
module tb_tictactoe_move_input;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic        clk;
  logic        reset;
  logic        btn_confirm;
  logic [3:0]  sw_position;
  logic [17:0] board_in;
  logic        game_over;
  logic        move_strobe;
  logic [3:0]  move_position;
  logic        move_player;
  logic        reject_strobe;
  logic [1:0]  reject_code;
  logic        next_player;
  logic [3:0]  move_count;

  tictactoe_move_input #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_confirm   (btn_confirm),
    .sw_position   (sw_position),
    .board_in      (board_in),
    .game_over     (game_over),
    .move_strobe   (move_strobe),
    .move_position (move_position),
    .move_player   (move_player),
    .reject_strobe (reject_strobe),
    .reject_code   (reject_code),
    .next_player   (next_player),
    .move_count    (move_count)
  );

  typedef struct {
    bit mv;
    int pos;
    bit pl;
    int code;
    int c;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit mv, input int pos, input bit pl, input int code, input int c);
    ev_t e;
    e.mv = mv; e.pos = pos; e.pl = pl; e.code = code; e.c = c;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cell(input int k, input logic [1:0] v);
    board_in[17-2*k -: 2] = v;
  endtask

  // kind: 0 = no strobe expected, 1 = move, 2 = reject
  task automatic press(input int pos, input int hold, input int kind, input bit pl, input int code);
    @(negedge clk);
    sw_position = 4'(pos);
    btn_confirm = 1'b1;
    if (kind == 1) push_ev(1'b1, pos, pl, 0, cyc + LAT);
    if (kind == 2) push_ev(1'b0, pos, 1'b0, code, cyc + LAT);
    tick(hold);
    btn_confirm = 1'b0;
    tick(10);
  endtask

  // One reset edge, then all outputs must read zero.
  task automatic reset_check(input string name);
    reset = 1'b1;
    @(negedge clk);
    chk(name, int'({move_strobe, reject_strobe, reject_code, move_position,
                    move_player, next_player, move_count}), 0);
    reset = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the queue, on the expected cycle.
  always @(negedge clk) begin
    if (!reset && (move_strobe || reject_strobe)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got move=%0d reject=%0d expected none (cycle %0d)",
                 move_strobe, reject_strobe, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.c);
        chk("move_strobe", int'(move_strobe), int'(e.mv));
        chk("reject_strobe", int'(reject_strobe), int'(!e.mv));
        chk("position", int'(move_position), e.pos);
        if (e.mv) chk("player", int'(move_player), int'(e.pl));
        else      chk("reject_code", int'(reject_code), e.code);
      end
    end else if (q.size() > 0 && q[0].c < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_strobe: got none expected event at cycle %0d (now %0d)", q[0].c, cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    int fill_cells[7];
    bit pl;
    int t0;
    fill_cells = '{1, 2, 3, 5, 6, 7, 8};
    reset       = 1'b1;
    btn_confirm = 1'b0;
    sw_position = 4'd0;
    board_in    = 18'd0;
    game_over   = 1'b0;
    tick(3);
    chk("reset_outputs", int'({move_strobe, reject_strobe, reject_code, move_position,
                               move_player, next_player, move_count}), 0);
    reset = 1'b0;

    // 1: clean press, long hold, empty board
    press(4, 20, 1, 1'b0, 0);
    set_cell(4, 2'b01);
    chk("t1_next_player", int'(next_player), 1);
    chk("t1_move_count", int'(move_count), 1);
    chk("t1_pos_hold", int'(move_position), 4);

    // 2: bouncy press; switch moves during debounce, final value 0
    @(negedge clk);
    sw_position = 4'd7;
    btn_confirm = 1'b1;
    tick(2);
    btn_confirm = 1'b0;
    tick(1);
    btn_confirm = 1'b1;
    push_ev(1'b1, 0, 1'b1, 0, cyc + LAT);
    tick(1);
    sw_position = 4'd0;
    tick(11);
    btn_confirm = 1'b0;
    tick(10);
    set_cell(0, 2'b10);
    chk("t2_next_player", int'(next_player), 0);
    chk("t2_move_count", int'(move_count), 2);

    // 3: occupied cell
    press(4, 12, 2, 1'b0, 2);
    chk("t3_next_player", int'(next_player), 0);
    chk("t3_move_count", int'(move_count), 2);

    // 4a: out of range
    press(11, 12, 2, 1'b0, 1);
    chk("t4_move_count", int'(move_count), 2);

    // Fill the rest of the board
    pl = 1'b0;
    foreach (fill_cells[i]) begin
      press(fill_cells[i], 12, 1, pl, 0);
      set_cell(fill_cells[i], pl ? 2'b10 : 2'b01);
      pl = ~pl;
    end
    chk("full_move_count", int'(move_count), 9);
    chk("full_next_player", int'(next_player), 1);

    // 4b: full outranks occupied and range
    press(0, 12, 2, 1'b0, 3);
    press(12, 12, 2, 1'b0, 3);
    chk("t4b_move_count", int'(move_count), 9);

    reset_check("reset_idle");
    board_in = 18'd0;

    // 5a: press ignored while game over
    game_over = 1'b1;
    press(3, 12, 0, 1'b0, 0);
    game_over = 1'b0;

    // 5b: game over raised during PRESS_DB
    @(negedge clk);
    sw_position = 4'd3;
    btn_confirm = 1'b1;
    tick(4);
    game_over = 1'b1;
    tick(10);
    btn_confirm = 1'b0;
    tick(10);
    game_over = 1'b0;
    chk("t5_move_count", int'(move_count), 0);
    chk("t5_next_player", int'(next_player), 0);
    press(2, 12, 1, 1'b0, 0);
    set_cell(2, 2'b01);
    chk("t5_after_count", int'(move_count), 1);

    // 6a: reset during PRESS_DB with button still held
    @(negedge clk);
    sw_position = 4'd6;
    btn_confirm = 1'b1;
    tick(4);
    reset_check("reset_press_db");
    board_in = 18'd0;
    push_ev(1'b1, 6, 1'b0, 0, cyc + LAT);
    tick(12);
    btn_confirm = 1'b0;
    tick(10);
    set_cell(6, 2'b01);

    // 6b: reset during RELEASE_DB
    @(negedge clk);
    sw_position = 4'd7;
    btn_confirm = 1'b1;
    t0 = cyc;
    push_ev(1'b1, 7, 1'b1, 0, t0 + LAT);
    tick(12);
    btn_confirm = 1'b0;
    tick(4);
    chk("t6_count_before_reset", int'(move_count), 2);
    reset_check("reset_release_db");
    board_in = 18'd0;
    tick(10);
    press(1, 12, 1, 1'b0, 0);
    chk("t6_move_count", int'(move_count), 1);
    chk("t6_next_player", int'(next_player), 1);

    tick(5);
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL leftover_event: got none expected event at cycle %0d", q[0].c);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
